mem_arbiter: RTL and testbench

// Single-port unified-memory arbiter for the MIPS core. Shares one synchronous RAM port among

---
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port unified-memory arbiter: CPU data (D), instruction fetch (I) and debug/loader (G)
// share one synchronous RAM port, with lane steering, byte enables and misalignment flags.

module mem_arb_dec (
  input  logic [1:0]  i_ofs,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_mis
);
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_mis   = |i_ofs;
    case (i_op)
      2'b01: begin
        o_be    = i_ofs[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_mis   = i_ofs[0];
      end
      2'b10: begin
        o_be    = 4'b0001 << i_ofs;
        o_wdata = {4{i_wdata[7:0]}};
        o_mis   = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

module mem_arbiter #(
  parameter int MEM_AW     = 10,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_d,
  input  logic [31:0]       addr_d,
  input  logic              we_d,
  input  logic [31:0]       wdata_d,
  input  logic [1:0]        memOp_d,
  output logic              gnt_d,
  output logic              rvalid_d,
  output logic [31:0]       rdata_d,
  output logic              err_d,
  input  logic              req_i,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        memOp_i,
  output logic              gnt_i,
  output logic              rvalid_i,
  output logic [31:0]       rdata_i,
  output logic              err_i,
  input  logic              req_g,
  input  logic [31:0]       addr_g,
  input  logic              we_g,
  input  logic [31:0]       wdata_g,
  input  logic [1:0]        memOp_g,
  output logic              gnt_g,
  output logic              rvalid_g,
  output logic [31:0]       rdata_g,
  output logic              err_g,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int NREQ = 3;
  localparam int CW   = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_D = 2'd1, OWN_I = 2'd2, OWN_G = 2'd3} owner_t;

  logic [NREQ-1:0]       w_req, w_we, w_mis, w_gnt, w_rv;
  logic [NREQ-1:0][31:0] w_addr, w_wdata, w_lwd, r_last;
  logic [NREQ-1:0][1:0]  w_op;
  logic [NREQ-1:0][3:0]  w_be;
  logic [1:0]            w_sel;
  logic                  w_any, w_promote;
  logic [CW-1:0]         r_starve;
  owner_t                r_owner, w_owner_nxt;
  logic [1:0]            r_ofs, r_op;
  logic [31:0]           w_sh, w_rlane;

  // Fetch is always a plain word read, whatever we_i/memOp_i say.
  assign w_req   = {req_g, req_i, req_d};
  assign w_we    = {we_g, 1'b0, we_d};
  assign w_addr  = {addr_g, addr_i, addr_d};
  assign w_wdata = {wdata_g, wdata_i, wdata_d};
  assign w_op    = {memOp_g, 2'b00, memOp_d};

  for (genvar g = 0; g < NREQ; g++) begin : g_dec
    mem_arb_dec u_dec (
      .i_ofs   (w_addr[g][1:0]),
      .i_op    (w_op[g]),
      .i_wdata (w_wdata[g]),
      .o_be    (w_be[g]),
      .o_wdata (w_lwd[g]),
      .o_mis   (w_mis[g])
    );
  end

  assign w_promote = req_g && (r_starve == CW'(STARVE_LIM));

  always_comb begin
    w_gnt = '0;
    w_sel = 2'd0;
    if (!rst) begin
      if (w_promote)    begin w_gnt[2] = 1'b1; w_sel = 2'd2; end
      else if (w_req[0]) begin w_gnt[0] = 1'b1; w_sel = 2'd0; end
      else if (w_req[1]) begin w_gnt[1] = 1'b1; w_sel = 2'd1; end
      else if (w_req[2]) begin w_gnt[2] = 1'b1; w_sel = 2'd2; end
    end
  end

  assign w_any = |w_gnt;
  assign gnt_d = w_gnt[0];
  assign gnt_i = w_gnt[1];
  assign gnt_g = w_gnt[2];
  assign err_d = w_gnt[0] & w_mis[0];
  assign err_i = w_gnt[1] & w_mis[1];
  assign err_g = w_gnt[2] & w_mis[2];

  // A misaligned grant still counts as service for starvation purposes.
  always_ff @(posedge clk) begin
    if (rst)                           r_starve <= '0;
    else if (req_g && !w_gnt[2]) begin
      if (r_starve != CW'(STARVE_LIM)) r_starve <= r_starve + CW'(1);
    end
    else                               r_starve <= '0;
  end

  always_comb begin
    mem_en    = w_any && !w_mis[w_sel];
    mem_we    = mem_en && w_we[w_sel];
    mem_be    = mem_en ? w_be[w_sel] : 4'b0000;
    mem_addr  = w_any ? w_addr[w_sel][MEM_AW+1:2] : '0;
    mem_wdata = mem_we ? w_lwd[w_sel] : 32'h0;
  end

  // Read-owner FSM: state register / next state / outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_NONE;
      r_ofs   <= 2'b00;
      r_op    <= 2'b00;
    end else begin
      r_owner <= w_owner_nxt;
      if (mem_en && !mem_we) begin
        r_ofs <= w_addr[w_sel][1:0];
        r_op  <= w_op[w_sel];
      end
    end
  end

  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (mem_en && !mem_we) begin
      case (w_sel)
        2'd0:    w_owner_nxt = OWN_D;
        2'd1:    w_owner_nxt = OWN_I;
        default: w_owner_nxt = OWN_G;
      endcase
    end
  end

  always_comb begin
    w_rv = '0;
    if (!rst) begin
      case (r_owner)
        OWN_D:   w_rv[0] = 1'b1;
        OWN_I:   w_rv[1] = 1'b1;
        OWN_G:   w_rv[2] = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_sh = mem_rdata >> {r_ofs, 3'b000};

  always_comb begin
    w_rlane = mem_rdata;
    case (r_op)
      2'b01:   w_rlane = {16'h0, r_ofs[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
      2'b10:   w_rlane = {24'h0, w_sh[7:0]};
      default: ;
    endcase
  end

  // Load data holds its last delivered value between reads.
  always_ff @(posedge clk) begin
    if (rst) r_last <= '0;
    else begin
      for (int k = 0; k < NREQ; k++)
        if (w_rv[k]) r_last[k] <= w_rlane;
    end
  end

  assign rvalid_d = w_rv[0];
  assign rvalid_i = w_rv[1];
  assign rvalid_g = w_rv[2];
  assign rdata_d  = w_rv[0] ? w_rlane : r_last[0];
  assign rdata_i  = w_rv[1] ? w_rlane : r_last[1];
  assign rdata_g  = w_rv[2] ? w_rlane : r_last[2];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural write-first RAM on the memory port.

module tb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1, pre_ld = 1'b0;
  logic        req_d, we_d, req_i, we_i, req_g, we_g;
  logic [31:0] addr_d, wdata_d, addr_i, wdata_i, addr_g, wdata_g;
  logic [1:0]  memOp_d, memOp_i, memOp_g;
  logic        gnt_d, rvalid_d, err_d, gnt_i, rvalid_i, err_i, gnt_g, rvalid_g, err_g;
  logic [31:0] rdata_d, rdata_i, rdata_g;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] ram [0:1023];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_AW(10), .STARVE_LIM(8)) dut (
    .clk(clk), .rst(rst),
    .req_d(req_d), .addr_d(addr_d), .we_d(we_d), .wdata_d(wdata_d), .memOp_d(memOp_d),
    .gnt_d(gnt_d), .rvalid_d(rvalid_d), .rdata_d(rdata_d), .err_d(err_d),
    .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .memOp_i(memOp_i),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i),
    .req_g(req_g), .addr_g(addr_g), .we_g(we_g), .wdata_g(wdata_g), .memOp_g(memOp_g),
    .gnt_g(gnt_g), .rvalid_g(rvalid_g), .rdata_g(rdata_g), .err_g(err_g),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_ld) begin
      ram[0]  <= 32'h11223344;
      ram[1]  <= 32'h55667788;
      ram[16] <= 32'hCAFEF00D;
    end
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic idle();
    req_d = 0; we_d = 0; addr_d = 0; wdata_d = 0; memOp_d = 0;
    req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0; memOp_i = 0;
    req_g = 0; we_g = 0; addr_g = 0; wdata_g = 0; memOp_g = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); req_d = 1; #2;
    total++; if (gnt_d !== 1'b0) begin bad++; $display("FAIL rst_gnt_d got=%0b exp=0", gnt_d); end
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%0b/%0b exp=0/0", mem_en, mem_we); end
    total++; if (mem_be !== 4'b0) begin bad++; $display("FAIL rst_mem_be got=%b exp=0000", mem_be); end
    total++; if ({rvalid_d, rvalid_i, rvalid_g, err_d} !== 4'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0000", {rvalid_d, rvalid_i, rvalid_g, err_d}); end
    idle();
  endtask

  task automatic test_priority();
    @(negedge clk); rst = 0; req_d = 1; addr_d = 32'h40; req_i = 1; addr_i = 32'h0; #2;
    total++; if ({gnt_d, gnt_i} !== 2'b10) begin bad++; $display("FAIL prio_t_gnt got=%b exp=10", {gnt_d, gnt_i}); end
    total++; if (mem_addr !== 10'd16 || mem_en !== 1'b1) begin bad++; $display("FAIL prio_t_addr got=%0d en=%0b exp=16 en=1", mem_addr, mem_en); end
    @(negedge clk); req_d = 0; #2;
    total++; if (gnt_i !== 1'b1) begin bad++; $display("FAIL prio_t1_gnt_i got=%0b exp=1", gnt_i); end
    total++; if (rvalid_d !== 1'b1 || rdata_d !== 32'hCAFEF00D) begin bad++; $display("FAIL prio_t1_rd got=%0b/%h exp=1/cafef00d", rvalid_d, rdata_d); end
    @(negedge clk); req_i = 0; #2;
    total++; if (rvalid_i !== 1'b1 || rdata_i !== 32'h11223344) begin bad++; $display("FAIL prio_t2_ri got=%0b/%h exp=1/11223344", rvalid_i, rdata_i); end
    total++; if (rvalid_d !== 1'b0 || rdata_d !== 32'hCAFEF00D) begin bad++; $display("FAIL prio_t2_hold got=%0b/%h exp=0/cafef00d", rvalid_d, rdata_d); end
  endtask

  task automatic test_load_lanes();
    @(negedge clk); req_d = 1; addr_d = 32'h2; memOp_d = 2'b10; #2;
    total++; if (mem_be !== 4'b0100) begin bad++; $display("FAIL lb_be got=%b exp=0100", mem_be); end
    @(negedge clk); memOp_d = 2'b01; #2;
    total++; if (rvalid_d !== 1'b1 || rdata_d !== 32'h00000022) begin bad++; $display("FAIL lb_data got=%0b/%h exp=1/00000022", rvalid_d, rdata_d); end
    total++; if (mem_be !== 4'b1100) begin bad++; $display("FAIL lh_be got=%b exp=1100", mem_be); end
    @(negedge clk); idle(); #2;
    total++; if (rvalid_d !== 1'b1 || rdata_d !== 32'h00001122) begin bad++; $display("FAIL lh_data got=%0b/%h exp=1/00001122", rvalid_d, rdata_d); end
  endtask

  task automatic test_store_lanes();
    @(negedge clk); req_d = 1; we_d = 1; addr_d = 32'h3; memOp_d = 2'b10; wdata_d = 32'h000000AB; #2;
    total++; if ({gnt_d, mem_en, mem_we} !== 3'b111) begin bad++; $display("FAIL sb_strobe got=%b exp=111", {gnt_d, mem_en, mem_we}); end
    total++; if (mem_be !== 4'b1000 || mem_wdata !== 32'hABABABAB) begin bad++; $display("FAIL sb_lane got=%b/%h exp=1000/abababab", mem_be, mem_wdata); end
    @(negedge clk); addr_d = 32'h6; memOp_d = 2'b01; wdata_d = 32'hFFFF1234; #2;
    total++; if (rvalid_d !== 1'b0) begin bad++; $display("FAIL sb_norvalid got=%0b exp=0", rvalid_d); end
    total++; if (mem_be !== 4'b1100 || mem_wdata !== 32'h12341234) begin bad++; $display("FAIL sh_lane got=%b/%h exp=1100/12341234", mem_be, mem_wdata); end
    @(negedge clk); we_d = 0; addr_d = 32'h0; memOp_d = 2'b00; #2;
    total++; if (mem_we !== 1'b0 || mem_be !== 4'b1111) begin bad++; $display("FAIL lw_be got=%0b/%b exp=0/1111", mem_we, mem_be); end
    @(negedge clk); idle(); #2;
    total++; if (rvalid_d !== 1'b1 || rdata_d !== 32'hAB223344) begin bad++; $display("FAIL wr_rd got=%0b/%h exp=1/ab223344", rvalid_d, rdata_d); end
  endtask

  task automatic test_misaligned();
    @(negedge clk); req_d = 1; addr_d = 32'h101; memOp_d = 2'b01; #2;
    total++; if ({gnt_d, err_d, mem_en} !== 3'b110) begin bad++; $display("FAIL mis_lh got=%b exp=110", {gnt_d, err_d, mem_en}); end
    @(negedge clk); idle(); req_i = 1; addr_i = 32'h2; #2;
    total++; if (rvalid_d !== 1'b0 || err_d !== 1'b0) begin bad++; $display("FAIL mis_norv got=%0b/%0b exp=0/0", rvalid_d, err_d); end
    total++; if ({gnt_i, err_i, mem_en} !== 3'b110) begin bad++; $display("FAIL mis_fetch got=%b exp=110", {gnt_i, err_i, mem_en}); end
    @(negedge clk); idle(); #2;
    total++; if (rvalid_i !== 1'b0) begin bad++; $display("FAIL mis_fetch_norv got=%0b exp=0", rvalid_i); end
  endtask

  task automatic test_starvation();
    @(negedge clk); req_d = 1; addr_d = 32'h4; req_i = 1; addr_i = 32'h8; req_g = 1; addr_g = 32'h40;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      total++; if (gnt_g !== (c == 8)) begin bad++; $display("FAIL starve_g c=%0d got=%0b exp=%0b", c, gnt_g, (c == 8)); end
      total++; if (gnt_d !== (c != 8)) begin bad++; $display("FAIL starve_d c=%0d got=%0b exp=%0b", c, gnt_d, (c != 8)); end
    end
    @(negedge clk); idle(); #2;
  endtask

  task automatic test_abandon();
    @(negedge clk); req_d = 1; req_g = 1; #2;
    total++; if (gnt_g !== 1'b0) begin bad++; $display("FAIL abn_wait got=%0b exp=0", gnt_g); end
    @(negedge clk); idle(); #2;
    total++; if ({gnt_g, err_g, mem_en} !== 3'b000) begin bad++; $display("FAIL abn_drop got=%b exp=000", {gnt_g, err_g, mem_en}); end
    @(negedge clk); req_g = 1; addr_g = 32'h0; #2;
    total++; if (gnt_g !== 1'b1) begin bad++; $display("FAIL g_alone got=%0b exp=1", gnt_g); end
    @(negedge clk); idle(); #2;
    total++; if (rvalid_g !== 1'b1 || rdata_g !== 32'hAB223344) begin bad++; $display("FAIL g_read got=%0b/%h exp=1/ab223344", rvalid_g, rdata_g); end
  endtask

  task automatic test_reset_read();
    @(negedge clk); req_d = 1; addr_d = 32'h40; #2;
    total++; if (gnt_d !== 1'b1) begin bad++; $display("FAIL rr_gnt got=%0b exp=1", gnt_d); end
    @(negedge clk); idle(); rst = 1; req_i = 1; #2;
    total++; if (rvalid_d !== 1'b0 || gnt_i !== 1'b0) begin bad++; $display("FAIL rr_suppress got=%0b/%0b exp=0/0", rvalid_d, gnt_i); end
    @(negedge clk); idle(); rst = 0; #2;
    total++; if ({rvalid_d, rvalid_i, rvalid_g, mem_en, mem_we} !== 5'b0) begin bad++; $display("FAIL rr_after got=%b exp=00000", {rvalid_d, rvalid_i, rvalid_g, mem_en, mem_we}); end
    total++; if (rdata_d !== 32'h0 || mem_be !== 4'b0) begin bad++; $display("FAIL rr_rdata got=%h/%b exp=0/0000", rdata_d, mem_be); end
  endtask

  initial begin
    idle();
    pre_ld = 1;
    @(negedge clk); pre_ld = 0;
    test_reset();
    test_priority();
    test_load_lanes();
    test_store_lanes();
    test_misaligned();
    test_starvation();
    test_abandon();
    test_reset_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
